mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single main-memory block port. It sits between two cache controllers (instruction-side requester 0, data-side requester 1) and the data memory. It grants one block transaction at a time and latches the winner's address, command and write block. It drives the memory read/write strobes and returns the fetched block with a completion pulse to the granted requester.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, grant/completion and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int AWIDTH     = 16,
  parameter int BLOCKWIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [AWIDTH-1:0]     addr0;
  logic [AWIDTH-1:0]     addr1;
  logic [BLOCKWIDTH-1:0] wdata0;
  logic [BLOCKWIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic [BLOCKWIDTH-1:0] rdata;
  logic [AWIDTH-1:0]     mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [BLOCKWIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [BLOCKWIDTH-1:0] mem_rdata;
  logic                  mem_done;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_ready, mem_rdata, mem_done,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  // Requester/memory environment side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_ready, mem_rdata, mem_done,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester block-port arbiter/sequencer; MEM_ARB_RR_EN selects round-robin over fixed priority
module mem_port_arbiter #(
  parameter int AWIDTH     = 16,
  parameter int BLOCKWIDTH = 32
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state, state_next;
  logic                  owner, owner_next;
  logic                  we_q, we_next;
  logic [AWIDTH-1:0]     addr_q, addr_next;
  logic [BLOCKWIDTH-1:0] wdata_q, wdata_next;
  logic [BLOCKWIDTH-1:0] rdata_q, rdata_next;
  logic                  gnt0_q, gnt0_next;
  logic                  gnt1_q, gnt1_next;
  logic                  done0_q, done0_next;
  logic                  done1_q, done1_next;
  logic                  rd_q, rd_next;
  logic                  wr_q, wr_next;
  logic                  win;
  logic [AWIDTH-1:0]     addr_sel;

`ifdef MEM_ARB_RR_EN
  logic                  last_q, last_next;

  // Winner on contention is whichever requester was not granted last
  always_comb begin
    win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  end
`else
  // Requester 0 always wins; requester 1 only when alone
  always_comb begin
    win = ~bus.req0;
  end
`endif

  // Next-state and next-output decode
  always_comb begin
    state_next = state;
    owner_next = owner;
    we_next    = we_q;
    addr_next  = addr_q;
    wdata_next = wdata_q;
    rdata_next = rdata_q;
    gnt0_next  = 1'b0;
    gnt1_next  = 1'b0;
    done0_next = 1'b0;
    done1_next = 1'b0;
    rd_next    = 1'b0;
    wr_next    = 1'b0;
    addr_sel   = win ? bus.addr1 : bus.addr0;
`ifdef MEM_ARB_RR_EN
    last_next  = last_q;
`endif
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_next = win;
          we_next    = win ? bus.we1 : bus.we0;
          addr_next  = addr_sel & {{(AWIDTH-2){1'b1}}, 2'b00};
          wdata_next = win ? bus.wdata1 : bus.wdata0;
          gnt0_next  = ~win;
          gnt1_next  = win;
`ifdef MEM_ARB_RR_EN
          last_next  = win;
`endif
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          rd_next    = ~we_q;
          wr_next    = we_q;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_done) begin
          if (!we_q) begin
            rdata_next = bus.mem_rdata;
          end
          done0_next = ~owner;
          done1_next = owner;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latched transaction and registered outputs; reset clears everything at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      we_q    <= we_next;
      addr_q  <= addr_next;
      wdata_q <= wdata_next;
      rdata_q <= rdata_next;
      gnt0_q  <= gnt0_next;
      gnt1_q  <= gnt1_next;
      done0_q <= done0_next;
      done1_q <= done1_next;
      rd_q    <= rd_next;
      wr_q    <= wr_next;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_next;
`endif
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  mem_port_arbiter_if #(.AWIDTH(16), .BLOCKWIDTH(32)) bus ();

  mem_port_arbiter #(.AWIDTH(16), .BLOCKWIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  {62'd0, bus.gnt1, bus.gnt0}, 64'd0);
    check({tag, "_done"}, {62'd0, bus.done1, bus.done0}, 64'd0);
    check({tag, "_strb"}, {62'd0, bus.mem_wr, bus.mem_rd}, 64'd0);
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_wdat"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_rdat"}, 64'(bus.rdata), 64'd0);
  endtask

  int exp_owner [4];
  int got_owner;
  int strobes;
  int dones;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0; bus.mem_done = 0;
`ifdef MEM_ARB_RR_EN
    exp_owner = '{0, 1, 0, 1};
`else
    exp_owner = '{0, 0, 0, 0};
`endif

    tick();
    tick();
    check_all_zero("rst");
    @(negedge clock);
    reset = 1'b1;

    // Single read from requester 0
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h1234; bus.mem_ready = 1;
    tick();
    check("rd_gnt", {62'd0, bus.gnt1, bus.gnt0}, 64'd1);
    check("rd_nostrobe", 64'(bus.mem_rd), 64'd0);
    tick();
    check("rd_strobe", {62'd0, bus.mem_wr, bus.mem_rd}, 64'd1);
    check("rd_addr", 64'(bus.mem_addr), 64'h1234);
    check("rd_gnt_pulse", 64'(bus.gnt0), 64'd0);
    tick();
    tick();
    tick();
    check("rd_early_done", 64'(bus.done0), 64'd0);
    bus.mem_done = 1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    check("rd_done", {62'd0, bus.done1, bus.done0}, 64'd1);
    check("rd_rdata", 64'(bus.rdata), 64'hDEADBEEF);
    bus.mem_done = 0; bus.mem_rdata = '0; bus.req0 = 0;
    tick();
    check("rd_done_pulse", 64'(bus.done0), 64'd0);
    tick();
    check("rd_no_regnt", {62'd0, bus.gnt1, bus.gnt0}, 64'd0);

    // Single write from requester 1
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h00A7; bus.wdata1 = 32'hCAFEF00D;
    tick();
    check("wr_gnt", {62'd0, bus.gnt1, bus.gnt0}, 64'd2);
    tick();
    check("wr_strobe", {62'd0, bus.mem_wr, bus.mem_rd}, 64'd2);
    check("wr_addr", 64'(bus.mem_addr), 64'h00A4);
    check("wr_wdata", 64'(bus.mem_wdata), 64'hCAFEF00D);
    bus.mem_done = 1; bus.mem_rdata = 32'hBAD0BAD0;
    tick();
    check("wr_done", {62'd0, bus.done1, bus.done0}, 64'd2);
    check("wr_rdata_kept", 64'(bus.rdata), 64'hDEADBEEF);
    bus.mem_done = 0; bus.mem_rdata = '0; bus.req1 = 0; bus.we1 = 0;
    tick();

    // Contention: both requesters held high over four transactions
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0100;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      got_owner = -1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.gnt0 || bus.gnt1) begin
          got_owner = bus.gnt1 ? 1 : 0;
          break;
        end
      end
      check($sformatf("cont_gnt%0d", k), 64'(got_owner), 64'(exp_owner[k]));
      tick();
      check($sformatf("cont_rd%0d", k), 64'(bus.mem_rd), 64'd1);
      bus.mem_done = 1; bus.mem_rdata = 32'h0000_1000 + 32'(k);
      tick();
      bus.mem_done = 0;
      check($sformatf("cont_done%0d", k), {62'd0, bus.done1, bus.done0},
            (exp_owner[k] == 1) ? 64'd2 : 64'd1);
      if (k == 3) begin
        bus.req0 = 0; bus.req1 = 0;
      end
    end
    tick();
    tick();

    // Backpressure: memory not ready for five cycles after the grant
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0043; bus.wdata0 = 32'h13579BDF;
    bus.mem_ready = 0;
    tick();
    check("bp_gnt", 64'(bus.gnt0), 64'd1);
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      strobes += int'(bus.mem_rd) + int'(bus.mem_wr);
    end
    check("bp_held", 64'(strobes), 64'd0);
    bus.mem_ready = 1;
    tick();
    check("bp_strobe", {62'd0, bus.mem_wr, bus.mem_rd}, 64'd2);
    check("bp_addr", 64'(bus.mem_addr), 64'h0040);
    strobes = 1;
    dones   = 0;
    bus.mem_done = 1;
    tick();
    bus.mem_done = 0;
    dones += int'(bus.done0) + int'(bus.done1);
    strobes += int'(bus.mem_rd) + int'(bus.mem_wr);
    bus.req0 = 0; bus.we0 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      dones   += int'(bus.done0) + int'(bus.done1);
      strobes += int'(bus.mem_rd) + int'(bus.mem_wr);
    end
    check("bp_one_strobe", 64'(strobes), 64'd1);
    check("bp_one_done", 64'(dones), 64'd1);

    // Reset asserted while waiting on memory
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0100;
    tick();
    check("rw_gnt", 64'(bus.gnt0), 64'd1);
    tick();
    check("rw_rd", 64'(bus.mem_rd), 64'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("rw_async");
    bus.req0 = 0;
    tick();
    tick();
    check_all_zero("rw_hold");
    @(negedge clock);
    reset = 1'b1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h020B;
    tick();
    check("rw_regnt", {62'd0, bus.gnt1, bus.gnt0}, 64'd1);
    tick();
    check("rw_rerd", 64'(bus.mem_rd), 64'd1);
    check("rw_readdr", 64'(bus.mem_addr), 64'h0208);
    bus.mem_done = 1; bus.mem_rdata = 32'h55AA55AA;
    tick();
    check("rw_done", 64'(bus.done0), 64'd1);
    check("rw_rdata", 64'(bus.rdata), 64'h55AA55AA);
    bus.mem_done = 0; bus.req0 = 0;
    tick();
    tick();

    // Spurious memory completion while idle
    bus.mem_done = 1; bus.mem_rdata = 32'h11111111;
    tick();
    bus.mem_done = 0;
    tick();
    check("sp_done", {62'd0, bus.done1, bus.done0}, 64'd0);
    check("sp_gnt", {62'd0, bus.gnt1, bus.gnt0}, 64'd0);
    check("sp_rdata", 64'(bus.rdata), 64'h55AA55AA);
    check("sp_strobe", {62'd0, bus.mem_wr, bus.mem_rd}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
